// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 host transmitter and the
// receive path of the keyboard controller.
//   ps2_tx_state_e  - transmitter FSM states
//   PS2_CMD_*       - common host-to-device command bytes
//   PS2_ACK_BYTE    - byte the keyboard returns after accepting a command
//   PS2_FRAME_BITS  - start + 8 data + parity + stop/ack slot
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    localparam int PS2_FRAME_BITS = 11;

    // Odd parity bit for a PS/2 data byte.
    function automatic logic ps2_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between the keyboard controller and the
// PS/2 host transmitter.
//   tx_data/tx_valid  - command byte and request (master -> slave)
//   tx_ready          - transmitter idle, request will be taken
//   tx_done/tx_err    - one-cycle completion / failure pulses
//   busy              - a frame is in progress (receive path ignores the bus)
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_err, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_err, busy
    );

endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS/2 clock and data pins into the clk domain
// and flags falling edges of the PS/2 clock.
//   clk, rst    - system clock, asynchronous active-low reset
//   clk_pin     - raw PS/2 clock pin level
//   data_pin    - raw PS/2 data pin level
//   clk_s       - synchronized PS/2 clock
//   data_s      - synchronized PS/2 data
//   clk_fe      - PS/2 clock falling edge, acted on at the third clk edge
//                 after the pin falls
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_pin,
    input  logic data_pin,
    output logic clk_s,
    output logic data_s,
    output logic clk_fe
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle bus level is high, so resetting to 1 avoids a spurious edge
    // right after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_pin};
            data_ff  <= {data_ff[0], data_pin};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
    assign clk_fe = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte per
// request over the shared open-drain ps2_clk/ps2_data lines; the lines are
// only ever pulled low through the *_oe enables, the tri-states live above.
//   clk, rst          - system clock, asynchronous active-low reset
//   tx                - command handshake (slave side of ps2_host_tx_if)
//   ps2_clk_in        - raw PS/2 clock pin level
//   ps2_data_in       - raw PS/2 data pin level
//   ps2_clk_oe        - 1 = pull PS/2 clock low
//   ps2_data_oe       - 1 = pull PS/2 data low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    ps2_host_tx_if.slave      tx,
    input  logic              ps2_clk_in,
    input  logic              ps2_data_in,
    output logic              ps2_clk_oe,
    output logic              ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_e state, state_d;
    logic [IW-1:0] inh_cnt, inh_cnt_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [8:0]    shift, shift_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          timed;

    logic clk_s, data_s, clk_fe;

    ps2_line_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_pin  (ps2_clk_in),
        .data_pin (ps2_data_in),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .clk_fe   (clk_fe)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            inh_cnt   <= inh_cnt_d;
            to_cnt    <= to_cnt_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // The line enables are registered alongside the state so the pins never
    // see decode glitches; each branch sets the level for the next cycle.
    always_comb begin
        state_d   = state;
        inh_cnt_d = inh_cnt;
        to_cnt_d  = to_cnt;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        timed = (state == ST_START) || (state == ST_SHIFT) || (state == ST_STOP) ||
                (state == ST_ACK)   || (state == ST_WAIT_IDLE);

        // Saturating watchdog from clock release to the end of the ACK.
        if (timed && (to_cnt != TW'(TIMEOUT_CYCLES)))
            to_cnt_d = to_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                inh_cnt_d = '0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx.tx_valid) begin
                    shift_d   = {ps2_parity(tx.tx_data), tx.tx_data};
                    state_d   = ST_INHIBIT;
                    clk_oe_d  = 1'b1;
                    // A one-cycle inhibit is also its own last cycle.
                    data_oe_d = (INHIBIT_CYCLES <= 1);
                end
            end

            ST_INHIBIT: begin
                if (inh_cnt != IW'(INHIBIT_CYCLES))
                    inh_cnt_d = inh_cnt + 1'b1;
                if (inh_cnt >= IW'(INHIBIT_CYCLES - 1)) begin
                    // Release the clock; the start bit (data low) stays.
                    state_d   = ST_START;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                end else if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
                    // Start bit goes out during the final inhibit cycle.
                    data_oe_d = 1'b1;
                end
            end

            ST_START: begin
                if (clk_fe) begin
                    data_oe_d = ~shift[0];
                    bit_cnt_d = 4'd1;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (clk_fe) begin
                    data_oe_d = ~shift[bit_cnt];
                    bit_cnt_d = bit_cnt + 4'd1;
                    // bit_cnt 8 is the parity bit, the last one we drive.
                    if (bit_cnt == 4'd8)
                        state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (clk_fe) begin
                    data_oe_d = 1'b0;
                    bit_cnt_d = bit_cnt + 4'd1;
                    state_d   = ST_ACK;
                end
            end

            ST_ACK: begin
                if (clk_fe) begin
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (!data_s) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        // Timeout overrides whatever the edge logic decided this cycle.
        if (timed && (to_cnt_d == TW'(TIMEOUT_CYCLES))) begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    assign tx.tx_ready = (state == ST_IDLE);
    assign tx.busy     = (state != ST_IDLE);
    assign tx.tx_done  = done_q;
    assign tx.tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple keyboard model
// clocking at 40 clk cycles per bit.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TMO = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_in, ps2_data_in;

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx          (tx_if.slave),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int checks = 0;
    int errors = 0;

    // Running event counts; tests take deltas around each scenario.
    int n_oe = 0, n_done = 0, n_err = 0, n_both = 0, n_bad = 0;
    always @(negedge clk) begin
        if (ps2_clk_oe) n_oe++;
        if (tx_if.tx_done) n_done++;
        if (tx_if.tx_err) n_err++;
        if (tx_if.tx_done && tx_if.tx_err) n_both++;
        if (tx_if.tx_ready === tx_if.busy) n_bad++;
    end

    // Keyboard model: waits for request-to-send, then clocks 11 bits,
    // sampling the line at the end of each high phase. bits[0] is the start
    // bit, bits[10] the stop bit.
    task automatic dev_run(input bit ack, output logic [10:0] bits, output bit ok);
        ok = 1'b0;
        bits = '0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ps2_clk_in && !ps2_data_in) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (10) @(negedge clk);
            bits[0] = ps2_data_in;
            for (int k = 1; k <= PS2_FRAME_BITS; k++) begin
                if (k == PS2_FRAME_BITS) begin
                    dev_data_low = ack;
                    repeat (5) @(negedge clk);
                end
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (20) @(negedge clk);
                if (k < PS2_FRAME_BITS) bits[k] = ps2_data_in;
            end
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    // One host request alongside the device model; hold55 keeps tx_valid
    // asserted with 0x55 for the whole frame.
    task automatic run_frame(input logic [7:0] b, input bit ack, input bit hold55,
                             output logic [10:0] bits, output bit dok, output bit hok);
        fork
            dev_run(ack, bits, dok);
            begin
                @(negedge clk);
                tx_if.tx_data  = b;
                tx_if.tx_valid = 1'b1;
                @(negedge clk);
                if (hold55) tx_if.tx_data = 8'h55;
                else        tx_if.tx_valid = 1'b0;
                hok = 1'b0;
                for (int i = 0; i < TMO + 500; i++) begin
                    if (tx_if.tx_ready) begin
                        hok = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                tx_if.tx_valid = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++; if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_if.tx_ready); end
        checks++; if (tx_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_if.busy); end
        checks++; if (tx_if.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_if.tx_done); end
        checks++; if (tx_if.tx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", tx_if.tx_err); end
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    endtask

    task automatic test_send_ed;
        logic [10:0] bits; bit dok, hok; int oe0, d0, e0;
        oe0 = n_oe; d0 = n_done; e0 = n_err;
        run_frame(PS2_CMD_SET_LEDS, 1'b1, 1'b0, bits, dok, hok);
        checks++; if (!(dok && hok)) begin errors++; $display("FAIL ed_complete: dev %b host %b want 1 1", dok, hok); end
        // start 0, ED LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1
        checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL ed_frame: got %h want 7da", bits); end
        checks++; if (n_oe - oe0 != INH) begin errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", n_oe - oe0, INH); end
        checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL ed_done: got %0d want 1", n_done - d0); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL ed_err: got %0d want 0", n_err - e0); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL ed_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    endtask

    task automatic test_parity;
        logic [10:0] bits; bit dok, hok; int d0;
        d0 = n_done;
        run_frame(PS2_CMD_ENABLE, 1'b1, 1'b0, bits, dok, hok);
        checks++; if (bits !== 11'h5E8) begin errors++; $display("FAIL f4_frame: got %h want 5e8", bits); end
        checks++; if (bits[9] !== 1'b0) begin errors++; $display("FAIL f4_parity: got %b want 0", bits[9]); end
        checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL f4_done: got %0d want 1", n_done - d0); end
        d0 = n_done;
        run_frame(PS2_CMD_RESET, 1'b1, 1'b0, bits, dok, hok);
        checks++; if (bits !== 11'h7FE) begin errors++; $display("FAIL ff_frame: got %h want 7fe", bits); end
        checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL ff_parity: got %b want 1", bits[9]); end
        checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL ff_done: got %0d want 1", n_done - d0); end
    endtask

    task automatic test_timeout;
        int cnt, d0; bit seen;
        d0 = n_done;
        @(negedge clk);
        tx_if.tx_data  = PS2_CMD_ENABLE;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < INH + 20; i++) begin
            if (!ps2_clk_oe) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_release: clk_oe stuck at %b want 0", ps2_clk_oe); end
        cnt = 0;
        for (int i = 0; i < TMO + 100; i++) begin
            @(negedge clk);
            cnt++;
            if (tx_if.tx_err) break;
        end
        checks++; if (cnt != TMO) begin errors++; $display("FAIL to_latency: got %0d want %0d", cnt, TMO); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL to_lines: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        checks++; if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b want 1", tx_if.tx_ready); end
        checks++; if (n_done - d0 != 0) begin errors++; $display("FAIL to_done: got %0d want 0", n_done - d0); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_no_ack;
        logic [10:0] bits; bit dok, hok; int d0, e0;
        d0 = n_done; e0 = n_err;
        run_frame(PS2_CMD_SET_LEDS, 1'b0, 1'b0, bits, dok, hok);
        checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL nack_frame: got %h want 7da", bits); end
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL nack_err: got %0d want 1", n_err - e0); end
        checks++; if (n_done - d0 != 0) begin errors++; $display("FAIL nack_done: got %0d want 0", n_done - d0); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits; bit dok, hok; int oe0, d0;
        oe0 = n_oe; d0 = n_done;
        run_frame(PS2_CMD_SET_LEDS, 1'b1, 1'b1, bits, dok, hok);
        repeat (40) @(negedge clk);
        checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL b2b_frame: got %h want 7da", bits); end
        checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", n_done - d0); end
        checks++; if (n_oe - oe0 != INH) begin errors++; $display("FAIL b2b_one_frame: clk_oe cycles %0d want %0d", n_oe - oe0, INH); end
        checks++; if (tx_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b want 0", tx_if.busy); end
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] bits; bit dok, hok; int d0, e0;
        d0 = n_done; e0 = n_err;
        fork
            dev_run(1'b1, bits, dok);
            begin
                @(negedge clk);
                tx_if.tx_data  = PS2_CMD_SET_LEDS;
                tx_if.tx_valid = 1'b1;
                @(negedge clk);
                tx_if.tx_valid = 1'b0;
                // Lands after the host has driven data bit 4 (a 0, so data_oe=1).
                repeat (205) @(negedge clk);
                checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL mid_pre_data_oe: got %b want 1", ps2_data_oe); end
                rst = 1'b0;
                #1;
                checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL mid_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
                checks++; if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", tx_if.tx_ready); end
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        checks++; if ((n_done - d0) + (n_err - e0) != 0) begin errors++; $display("FAIL mid_pulses: done %0d err %0d want 0 0", n_done - d0, n_err - e0); end
        d0 = n_done;
        run_frame(PS2_CMD_RESET, 1'b1, 1'b0, bits, dok, hok);
        checks++; if (bits !== 11'h7FE) begin errors++; $display("FAIL mid_next_frame: got %h want 7fe", bits); end
        checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL mid_next_done: got %0d want 1", n_done - d0); end
    endtask

    initial begin
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        test_send_ed();
        repeat (10) @(negedge clk);
        test_parity();
        repeat (10) @(negedge clk);
        test_timeout();
        test_no_ack();
        repeat (10) @(negedge clk);
        test_back_to_back();
        test_reset_mid_frame();
        checks++; if (n_both != 0) begin errors++; $display("FAIL done_err_overlap: got %0d want 0", n_both); end
        checks++; if (n_bad != 0) begin errors++; $display("FAIL ready_busy_consistency: got %0d want 0", n_bad); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
